// File: rtl/mux_arb_n.sv
// N-channel registered multiplexer with valid/ready handshakes and an internal
// fixed-priority (MODE=0) or round-robin (MODE=1) arbiter.
module mux_arb_n #(
    parameter int W    = 32,
    parameter int N    = 2,
    parameter int MODE = 0,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*W-1:0]     in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    logic               r_out_valid;
    logic [W-1:0]       r_out_data;
    logic [SEL_W-1:0]   r_out_sel;
    logic [SEL_W-1:0]   r_ptr;

    logic               w_load_en;
    logic               w_found;
    logic [N-1:0]       w_onehot;
    logic [SEL_W-1:0]   w_gnt_idx;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [W-1:0]       w_gnt_data;

    assign w_load_en = !r_out_valid || out_ready;

    // Scan starts at r_ptr in round-robin mode, at 0 in fixed-priority mode;
    // the first requesting channel found wins.
    always_comb begin
        int j;
        j          = 0;
        w_found    = 1'b0;
        w_onehot   = '0;
        w_gnt_idx  = '0;
        w_ptr_nxt  = '0;
        w_gnt_data = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 1) begin
                j = (int'(r_ptr) + k) % N;
            end else begin
                j = k;
            end
            if (!w_found && in_valid[j]) begin
                w_found     = 1'b1;
                w_onehot[j] = 1'b1;
                w_gnt_idx   = SEL_W'(j);
                w_ptr_nxt   = SEL_W'((j + 1) % N);
                w_gnt_data  = in_data[j*W +: W];
            end
        end
    end

    assign in_ready = (!reset && w_load_en && w_found) ? w_onehot : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_sel   <= w_gnt_idx;
                if (MODE == 1) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: one fixed-priority and one round-robin instance,
// both W=32, N=4.
module tb_mux_arb_n;

    localparam int W = 32;
    localparam int N = 4;
    localparam int SEL_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               fp_reset, rr_reset;
    logic [N-1:0]       fp_in_valid, rr_in_valid;
    logic [N*W-1:0]     fp_in_data, rr_in_data;
    logic [N-1:0]       fp_in_ready, rr_in_ready;
    logic               fp_out_valid, rr_out_valid;
    logic [W-1:0]       fp_out_data, rr_out_data;
    logic [SEL_W-1:0]   fp_out_sel, rr_out_sel;
    logic               fp_out_ready, rr_out_ready;

    int n_cmp = 0;
    int n_err = 0;

    mux_arb_n #(.W(W), .N(N), .MODE(0)) u_fp (
        .clk(clk), .reset(fp_reset),
        .in_valid(fp_in_valid), .in_data(fp_in_data), .in_ready(fp_in_ready),
        .out_valid(fp_out_valid), .out_data(fp_out_data), .out_sel(fp_out_sel),
        .out_ready(fp_out_ready)
    );

    mux_arb_n #(.W(W), .N(N), .MODE(1)) u_rr (
        .clk(clk), .reset(rr_reset),
        .in_valid(rr_in_valid), .in_data(rr_in_data), .in_ready(rr_in_ready),
        .out_valid(rr_out_valid), .out_data(rr_out_data), .out_sel(rr_out_sel),
        .out_ready(rr_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        fp_reset = 1'b1; rr_reset = 1'b1;
        fp_in_valid = 4'b1111; rr_in_valid = 4'b1111;
        fp_in_data = '0; rr_in_data = '0;
        fp_out_ready = 1'b1; rr_out_ready = 1'b1;
        for (int i = 0; i < N; i++) rr_in_data[i*W +: W] = i;
        #1;
        chk("fp_ready_in_reset", 32'(fp_in_ready), 32'h0);
        chk("rr_ready_in_reset", 32'(rr_in_ready), 32'h0);
        tick();
        chk("fp_ready_in_reset2", 32'(fp_in_ready), 32'h0);
        chk("fp_rst_valid", 32'(fp_out_valid), 32'h0);
        chk("fp_rst_data", fp_out_data, 32'h0);
        chk("fp_rst_sel", 32'(fp_out_sel), 32'h0);
        chk("rr_rst_valid", 32'(rr_out_valid), 32'h0);
        fp_reset = 1'b0; rr_reset = 1'b0;
        fp_in_valid = '0; rr_in_valid = '0;
        tick();
        chk("fp_idle_valid", 32'(fp_out_valid), 32'h0);

        // Fixed priority: channel 1 always beats channel 3
        fp_in_valid = 4'b1010;
        fp_in_data[1*W +: W] = 32'h1111_0001;
        fp_in_data[3*W +: W] = 32'h3333_0003;
        #1;
        chk("fp_prio_ready0", 32'(fp_in_ready), 32'h2);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("fp_prio_ready", 32'(fp_in_ready), 32'h2);
            chk("fp_prio_valid", 32'(fp_out_valid), 32'h1);
            chk("fp_prio_data", fp_out_data, 32'h1111_0001);
            chk("fp_prio_sel", 32'(fp_out_sel), 32'h1);
        end
        fp_in_valid = '0;
        tick();
        chk("fp_drain_valid", 32'(fp_out_valid), 32'h0);
        chk("fp_drain_hold_data", fp_out_data, 32'h1111_0001);
        chk("fp_drain_hold_sel", 32'(fp_out_sel), 32'h1);

        // Backpressure
        fp_in_valid = 4'b0100;
        fp_in_data[2*W +: W] = 32'hDEAD_BEEF;
        fp_in_data[0*W +: W] = 32'h0000_00A5;
        #1;
        chk("fp_bp_grant2", 32'(fp_in_ready), 32'h4);
        tick();
        fp_out_ready = 1'b0;
        fp_in_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("fp_bp_ready", 32'(fp_in_ready), 32'h0);
            chk("fp_bp_valid", 32'(fp_out_valid), 32'h1);
            chk("fp_bp_data", fp_out_data, 32'hDEAD_BEEF);
            chk("fp_bp_sel", 32'(fp_out_sel), 32'h2);
            tick();
        end
        fp_out_ready = 1'b1;
        #1;
        chk("fp_release_ready", 32'(fp_in_ready), 32'h1);
        chk("fp_release_data_pre", fp_out_data, 32'hDEAD_BEEF);
        tick();
        chk("fp_release_valid", 32'(fp_out_valid), 32'h1);
        chk("fp_release_data", fp_out_data, 32'h0000_00A5);
        chk("fp_release_sel", 32'(fp_out_sel), 32'h0);
        fp_in_valid = '0;
        tick();
        chk("fp_end_valid", 32'(fp_out_valid), 32'h0);

        // Round-robin fairness: ptr starts at 0
        rr_in_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_fair_ready", 32'(rr_in_ready), 32'(1 << (c % 4)));
            tick();
            chk("rr_fair_valid", 32'(rr_out_valid), 32'h1);
            chk("rr_fair_sel", 32'(rr_out_sel), 32'(c % 4));
            chk("rr_fair_data", rr_out_data, 32'(c % 4));
        end
        rr_in_valid = '0;
        tick();
        chk("rr_idle_valid", 32'(rr_out_valid), 32'h0);

        // Skip and wrap: grant 2 -> ptr=3; then 0 -> ptr=1; then 3 beats 0
        rr_in_valid = 4'b0100;
        #1;
        chk("rr_skip_ready2", 32'(rr_in_ready), 32'h4);
        tick();
        chk("rr_skip_sel2", 32'(rr_out_sel), 32'h2);
        rr_in_valid = 4'b0001;
        #1;
        chk("rr_wrap_ready0", 32'(rr_in_ready), 32'h1);
        tick();
        chk("rr_wrap_sel0", 32'(rr_out_sel), 32'h0);
        rr_in_valid = 4'b1001;
        #1;
        chk("rr_wrap_ready3", 32'(rr_in_ready), 32'h8);
        tick();
        chk("rr_wrap_sel3", 32'(rr_out_sel), 32'h3);
        chk("rr_wrap_data3", rr_out_data, 32'h3);

        // Reset mid-stall: ptr=0 here; grant 1 moves it to 2, then stall
        rr_in_valid = 4'b0010;
        tick();
        chk("rr_stall_sel1", 32'(rr_out_sel), 32'h1);
        rr_out_ready = 1'b0;
        rr_in_valid = 4'b1111;
        #1;
        chk("rr_stall_ready", 32'(rr_in_ready), 32'h0);
        tick();
        chk("rr_stall_valid", 32'(rr_out_valid), 32'h1);
        chk("rr_stall_data", rr_out_data, 32'h1);
        rr_reset = 1'b1;
        #1;
        chk("rr_midrst_ready", 32'(rr_in_ready), 32'h0);
        tick();
        rr_reset = 1'b0;
        chk("rr_midrst_valid", 32'(rr_out_valid), 32'h0);
        chk("rr_midrst_data", rr_out_data, 32'h0);
        chk("rr_midrst_sel", 32'(rr_out_sel), 32'h0);
        rr_out_ready = 1'b1;
        #1;
        chk("rr_midrst_ptr_ready", 32'(rr_in_ready), 32'h1);
        tick();
        chk("rr_midrst_ptr_sel", 32'(rr_out_sel), 32'h0);
        chk("rr_midrst_ptr_valid", 32'(rr_out_valid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes and built-in arbitration.
- Replaces hard-wired 32-bit 2:1 selects wherever several producers share one consumer, e.g. writeback sources, memory request ports, or debug/bus taps.
- Selection comes from an internal arbiter (fixed-priority or round-robin), not a select input.
- Result is delivered through a one-entry output register, so downstream timing is decoupled.

Parameters:
- W, 32, data width per channel in bits (>=1).
- N, 2, number of input channels (>=1).
- MODE, 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
- SEL_W (localparam), max(1, clog2(N)), width of the channel index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel request; bit i asserts that channel i data is valid.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W].
- in_ready  output  N  per-channel accept, one-hot or zero; channel i transfers when in_valid[i] && in_ready[i].
- out_valid  output  1  output register holds a valid word.
- out_data  output  W  registered selected data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready is forced to all-zero while reset=1.
- load_en = !out_valid || out_ready. The output register may accept new data only when load_en=1.
- Grant, combinational:
  - If load_en=1 and in_valid!=0, exactly one channel g is granted and in_ready = onehot(g).
  - Otherwise in_ready=0.
  - in_ready may depend on in_valid. in_valid must not depend on in_ready.
- MODE=0: g = lowest index i with in_valid[i]=1.
- MODE=1:
  - g = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - On a transfer, ptr <= (g+1) mod N. ptr is unchanged on cycles without an input transfer.
- Register update at the clock edge:
  - On a grant: out_valid<=1, out_data<=in_data[g], out_sel<=g.
  - If load_en=1 and no in_valid: out_valid<=0; out_data and out_sel hold their values.
  - If load_en=0: all outputs hold.
- Latency and throughput:
  - Latency is 1 cycle from the input transfer edge to out_valid.
  - Throughput is 1 word per cycle while out_ready=1 continuously.
- Stall: while out_valid=1 and out_ready=0, out_data and out_sel stay bit-stable and in_ready=0.
- Simultaneous events: an output transfer and a new input grant in the same cycle are allowed. The register is replaced with no bubble.
- Reset mid-operation: a word held in the register is discarded, no in_ready is asserted in the reset cycle, and ptr returns to 0.
- Wrap-around: in MODE=1, a grant of channel N-1 sets ptr=0. With N=1, ptr stays 0 and the block is a registered pipe stage.
- Fairness: in MODE=1 with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,...
- No combinational path from in_* to out_*. The only combinational paths are out_ready -> in_ready and in_valid -> in_ready.

Test Plan:
- Reset check (W=32, N=4, MODE=0): assert reset with in_valid=4'b1111 -> in_ready=0 during reset; out_valid=0, out_data=0, out_sel=0 after reset.
- Fixed priority (MODE=0): in_valid=4'b1010 held, channel 1 data 32'h1111_0001, channel 3 data 32'h3333_0003, out_ready=1 -> in_ready=4'b0010 every cycle; out_data=32'h1111_0001 with out_sel=1 from cycle 2 onward; channel 3 is never granted.
- Round-robin fairness (MODE=1): all 4 channels valid, channel i data = i, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_data matching, back-to-back with no bubbles.
- Backpressure: grant channel 2 (data 32'hDEAD_BEEF), then out_ready=0 for 3 cycles -> out_valid=1, out_data=32'hDEAD_BEEF, out_sel=2 stable and in_ready=0 throughout. Release -> the next grant is accepted in the same cycle as the output transfer.
- Round-robin skip and wrap (MODE=1): ptr=3 after granting channel 2, then in_valid=4'b0001 -> channel 0 granted, ptr=1. Next in_valid=4'b1001 -> channel 3 granted before channel 0.
- Reset mid-stall: out_valid=1 with out_ready=0, assert reset for 1 cycle -> next cycle out_valid=0, out_data=0, and ptr=0 (next MODE=1 grant with in_valid=4'b1111 is channel 0).
